// File: rtl/onchip_dpram_avmm_if.sv
// Avalon-MM slave port bundle for one side of the dual-port RAM.
// Slave sees requests as inputs; read data, valid and stall flow back to the master.
interface onchip_dpram_avmm_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_dpram_avmm.sv
// True-dual-port byte-enabled RAM, two Avalon-MM ports, optional clear-after-reset.
// Read data READ_LATENCY cycles after accept; both ports stall only while clearing.
module onchip_dpram_avmm #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  onchip_dpram_avmm_if.slave a,
  onchip_dpram_avmm_if.slave b,
  output logic               init_done,
  output logic               collision
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
    $error("onchip_dpram_avmm: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("onchip_dpram_avmm: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we, stall;

  // Index 0 is port A, index 1 is port B.
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [NB-1:0]         be   [2];
  logic [DATA_WIDTH-1:0] wdat [2];
  logic [1:0]            rd_acc, wr_acc;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [1:0]            s1_vld_q, s1_vld_d, rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] s1_dat_q [2];
  logic [DATA_WIDTH-1:0] s1_dat_d [2];
  logic [DATA_WIDTH-1:0] rd_dat_q [2];
  logic [DATA_WIDTH-1:0] rd_dat_d [2];
  logic                  collision_q, collision_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  assign stall = (state_q == ST_CLEAR);

  always_comb begin
    addr[0] = a.address;  be[0] = a.byteenable;  wdat[0] = a.writedata;
    addr[1] = b.address;  be[1] = b.byteenable;  wdat[1] = b.writedata;
    // A write with read also set is a write only.
    wr_acc[0] = a.chipselect & a.write & ~stall;
    wr_acc[1] = b.chipselect & b.write & ~stall;
    rd_acc[0] = a.chipselect & a.read & ~a.write & ~stall;
    rd_acc[1] = b.chipselect & b.read & ~b.write & ~stall;
    collision_d = wr_acc[0] & wr_acc[1] & (addr[0] == addr[1]);
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s1_vld_d[p] = rd_acc[p];
      s1_dat_d[p] = mem_q[addr[p]];
      if (READ_LATENCY == 1) begin
        rd_vld_d[p] = rd_acc[p];
        rd_dat_d[p] = rd_acc[p] ? mem_q[addr[p]] : rd_dat_q[p];
      end else begin
        rd_vld_d[p] = s1_vld_q[p];
        rd_dat_d[p] = s1_vld_q[p] ? s1_dat_q[p] : rd_dat_q[p];
      end
    end
  end

  // B is applied first so A's later assignment wins on shared lanes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_acc[p] && be[p][i]) mem_q[addr[p]][8*i +: 8] <= wdat[p][8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      s1_vld_q    <= '0;
      rd_vld_q    <= '0;
      collision_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        s1_dat_q[p] <= '0;
        rd_dat_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      s1_vld_q    <= s1_vld_d;
      rd_vld_q    <= rd_vld_d;
      collision_q <= collision_d;
      for (int p = 0; p < 2; p++) begin
        s1_dat_q[p] <= s1_dat_d[p];
        rd_dat_q[p] <= rd_dat_d[p];
      end
    end
  end

  assign a.readdata      = rd_dat_q[0];
  assign a.readdatavalid = rd_vld_q[0];
  assign a.waitrequest   = stall;
  assign b.readdata      = rd_dat_q[1];
  assign b.readdatavalid = rd_vld_q[1];
  assign b.waitrequest   = stall;
  assign init_done       = (state_q == ST_READY);
  assign collision       = collision_q;
endmodule

// File: tb/tb_onchip_dpram_avmm.sv
// Bench: latency-1 and latency-2 instances driven in lockstep, checked by a queue scoreboard
// against a word-array model of the memory.
module tb_onchip_dpram_avmm;
  localparam int          AW = 4;
  localparam int          DW = 32;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onchip_dpram_avmm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1(), b1(), a2(), b2();
  logic init1, init2, col1, col2;

  onchip_dpram_avmm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
                      .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .a(a1), .b(b1), .init_done(init1), .collision(col1));
  onchip_dpram_avmm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
                      .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .a(a2), .b(b2), .init_done(init2), .collision(col2));

  assign a2.address = a1.address;  assign a2.chipselect = a1.chipselect;
  assign a2.read    = a1.read;     assign a2.write      = a1.write;
  assign a2.byteenable = a1.byteenable;  assign a2.writedata = a1.writedata;
  assign b2.address = b1.address;  assign b2.chipselect = b1.chipselect;
  assign b2.read    = b1.read;     assign b2.write      = b1.write;
  assign b2.byteenable = b1.byteenable;  assign b2.writedata = b1.writedata;

  typedef struct { logic [31:0] dat; int cyc; } exp_t;
  exp_t        expq [4][$];
  int          colq [2][$];
  logic [31:0] model [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_idle();
    a1.chipselect = 1'b0; a1.read = 1'b0; a1.write = 1'b0;
    a1.address = '0; a1.byteenable = '0; a1.writedata = '0;
    b1.chipselect = 1'b0; b1.read = 1'b0; b1.write = 1'b0;
    b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
  endtask

  // One bus cycle on both ports; the model predicts read results and collisions.
  task automatic drive(input bit acs, input bit ard, input bit awr, input logic [3:0] aad,
                       input logic [3:0] abe, input logic [31:0] awd,
                       input bit bcs, input bit brd, input bit bwr, input logic [3:0] bad,
                       input logic [3:0] bbe, input logic [31:0] bwd);
    bit ar, aw, br, bw;
    logic [31:0] w;
    a1.chipselect = acs; a1.read = ard; a1.write = awr;
    a1.address = aad; a1.byteenable = abe; a1.writedata = awd;
    b1.chipselect = bcs; b1.read = brd; b1.write = bwr;
    b1.address = bad; b1.byteenable = bbe; b1.writedata = bwd;
    ar = acs && ard && !awr;  aw = acs && awr;
    br = bcs && brd && !bwr;  bw = bcs && bwr;
    if (ar) begin
      expq[0].push_back('{dat: model[aad], cyc: cyc + 1});
      expq[2].push_back('{dat: model[aad], cyc: cyc + 2});
    end
    if (br) begin
      expq[1].push_back('{dat: model[bad], cyc: cyc + 1});
      expq[3].push_back('{dat: model[bad], cyc: cyc + 2});
    end
    if (aw && bw && aad == bad) begin
      colq[0].push_back(cyc + 1);
      colq[1].push_back(cyc + 1);
    end
    if (bw) begin
      w = model[bad];
      for (int i = 0; i < 4; i++) if (bbe[i]) w[8*i +: 8] = bwd[8*i +: 8];
      model[bad] = w;
    end
    if (aw) begin
      w = model[aad];
      for (int i = 0; i < 4; i++) if (abe[i]) w[8*i +: 8] = awd[8*i +: 8];
      model[aad] = w;
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_a(input logic [3:0] ad, input logic [3:0] be, input logic [31:0] d);
    drive(1, 0, 1, ad, be, d, 0, 0, 0, 4'd0, 4'd0, 32'd0);
  endtask
  task automatic rd_b(input logic [3:0] ad);
    drive(0, 0, 0, 4'd0, 4'd0, 32'd0, 1, 1, 0, ad, 4'd0, 32'd0);
  endtask

  task automatic count_clear(input string nm);
    int n;
    n = 0;
    while ((a1.waitrequest || a2.waitrequest) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_cycles"}, n, 16);
    chk({nm, "_init_done"}, {init1, init2}, 2'b11);
    chk({nm, "_wait_low"}, {a1.waitrequest, b1.waitrequest, a2.waitrequest, b2.waitrequest}, 4'h0);
    for (int i = 0; i < 16; i++) model[i] = CV;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++)
      drive(1, 1, 0, 4'(i), 4'd0, 32'd0, 1, 1, 0, 4'(15 - i), 4'd0, 32'd0);
    set_idle();
  endtask

  // Scoreboard monitor
  logic        vld [4];
  logic [31:0] dat [4];
  logic [31:0] last [4] = '{default: 32'd0};
  logic        col [2];
  exp_t        e;
  assign vld[0] = a1.readdatavalid; assign dat[0] = a1.readdata;
  assign vld[1] = b1.readdatavalid; assign dat[1] = b1.readdata;
  assign vld[2] = a2.readdatavalid; assign dat[2] = a2.readdata;
  assign vld[3] = b2.readdatavalid; assign dat[3] = b2.readdata;
  assign col[0] = col1;             assign col[1] = col2;

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (vld[p]) begin
        if (expq[p].size() == 0) begin
          errors++;
          $display("FAIL rdata_p%0d unexpected valid cycle=%0d data=%h", p, cyc, dat[p]);
        end else begin
          e = expq[p].pop_front();
          if (dat[p] !== e.dat || cyc != e.cyc) begin
            errors++;
            $display("FAIL rdata_p%0d actual=%h@%0d required=%h@%0d", p, dat[p], cyc, e.dat, e.cyc);
          end
        end
        last[p] = dat[p];
      end else begin
        if (!reset_n) last[p] = 32'd0;
        if (dat[p] !== last[p]) begin
          errors++;
          $display("FAIL rdata_hold_p%0d actual=%h required=%h", p, dat[p], last[p]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (col[d]) begin
        checks++;
        if (colq[d].size() == 0 || colq[d][0] != cyc) begin
          errors++;
          $display("FAIL collision_d%0d unexpected pulse at cycle %0d", d, cyc);
        end else begin
          void'(colq[d].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ra, rb, bea, beb;
    logic [31:0] da, db;
    set_idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", {a1.waitrequest, b1.waitrequest, a2.waitrequest, b2.waitrequest}, 4'hF);
    chk("rst_init", {init1, init2}, 2'b00);
    chk("rst_rvalid", {vld[0], vld[1], vld[2], vld[3]}, 4'h0);
    chk("rst_col", {col1, col2}, 2'b00);
    chk("rst_rdata", dat[0] | dat[1] | dat[2] | dat[3], 32'd0);
    reset_n = 1'b1;
    count_clear("clear1");
    read_all();

    for (int i = 0; i < 16; i++) wr_a(4'(i), 4'hF, $urandom());
    set_idle();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midclr_wait", {a1.waitrequest, b1.waitrequest, a2.waitrequest, b2.waitrequest}, 4'hF);
    chk("midclr_init", {init1, init2}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    count_clear("clear2");
    read_all();

    // Partial-lane write over a zero word, read back from B
    wr_a(4'd5, 4'hF, 32'h0);
    wr_a(4'd5, 4'b0101, 32'h11223344);
    rd_b(4'd5);
    // Dual write to one address: A owns shared lanes
    drive(1, 0, 1, 4'd9, 4'b0011, 32'hAAAAAAAA, 1, 0, 1, 4'd9, 4'b1111, 32'hBBBBBBBB);
    set_idle();
    @(posedge clk); #1;
    drive(1, 1, 0, 4'd9, 4'd0, 32'd0, 1, 1, 0, 4'd9, 4'd0, 32'd0);
    // Write on A while B reads the same word returns the old value
    wr_a(4'd3, 4'hF, 32'h1);
    drive(1, 0, 1, 4'd3, 4'hF, 32'h2, 1, 1, 0, 4'd3, 4'd0, 32'd0);
    rd_b(4'd3);
    // Back-to-back reads with no bubbles
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 4'(i), 4'd0, 32'd0, 0, 0, 0, 4'd0, 4'd0, 32'd0);
    // Same-port read right after write
    wr_a(4'd12, 4'hF, 32'hCAFEF00D);
    drive(1, 1, 0, 4'd12, 4'd0, 32'd0, 0, 0, 0, 4'd0, 4'd0, 32'd0);

    for (int it = 0; it < 400; it++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      bea = 4'($urandom());
      beb = 4'($urandom());
      da  = $urandom();
      db  = $urandom();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            ra, bea, da,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            rb, beb, db);
    end
    set_idle();
    read_all();
    repeat (8) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("drain_rd_p%0d", p), expq[p].size(), 0);
    for (int d = 0; d < 2; d++) chk($sformatf("drain_col_d%0d", d), colq[d].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
